// File: rtl/fft_arith_pkg.sv
// Shared arithmetic constants and stage records for the FFT/NTT butterfly datapath.
package fft_arith_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_MODULUS = 65521;
    localparam int CLA_CELL_W  = 2;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] d;
        logic                 borrow;
        logic                 valid;
    } stage_t;

endpackage

// File: rtl/cla_add_n.sv
// Generic WIDTH-bit carry-lookahead adder, a ripple of 2-bit CLA cells.
module cla2_cell (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       c_in,
    output logic [1:0] sum,
    output logic       c_out
);

    logic [1:0] g;
    logic [1:0] p;
    logic       c1;

    assign g     = a & b;
    assign p     = a ^ b;
    assign c1    = g[0] | (p[0] & c_in);
    assign c_out = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign sum   = p ^ {c1, c_in};

endmodule

module cla_add_n
    import fft_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int NG = WIDTH / CLA_CELL_W;

    logic [NG:0] c;

    assign c[0]  = c_in;
    assign c_out = c[NG];

    for (genvar g = 0; g < NG; g++) begin : g_cell
        cla2_cell u_cell (
            .a    (a[g*CLA_CELL_W +: CLA_CELL_W]),
            .b    (b[g*CLA_CELL_W +: CLA_CELL_W]),
            .c_in (c[g]),
            .sum  (sum[g*CLA_CELL_W +: CLA_CELL_W]),
            .c_out(c[g+1])
        );
    end

endmodule

// File: rtl/cla_mod_sub_pipe.sv
// Two-stage elastic modular subtractor: diff = (a - b) mod MODULUS.
// Optional operand range check: define CLA_MOD_SUB_RANGE_CHECK_EN.
module cla_mod_sub_pipe
    import fft_arith_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] MODULUS = WIDTH'(DEF_MODULUS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
`ifdef CLA_MOD_SUB_RANGE_CHECK_EN
    ,
    output logic             range_err
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             borrow;
        logic             valid;
    } stage_w_t;

    stage_w_t         s1;
    logic             adv1;
    logic             adv2;
    logic [WIDTH-1:0] sub_d;
    logic             sub_c;
    logic [WIDTH-1:0] fix_d;
    logic [WIDTH-1:0] next_diff;

    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~s1.valid | adv2;
    assign in_ready = adv1;

    cla_add_n #(.WIDTH(WIDTH)) u_sub (
        .a    (a_in),
        .b    (~b_in),
        .c_in (1'b1),
        .sum  (sub_d),
        .c_out(sub_c)
    );

    // Wrap-around carry of the correction is always discarded.
    cla_add_n #(.WIDTH(WIDTH)) u_fix (
        .a    (s1.d),
        .b    (MODULUS),
        .c_in (1'b0),
        .sum  (fix_d),
        .c_out()
    );

`ifdef CLA_MOD_SUB_RANGE_CHECK_EN
    logic s1_err;
    logic in_err;

    assign in_err = (a_in >= MODULUS) | (b_in >= MODULUS);

    always_comb begin
        next_diff = s1.borrow ? fix_d : s1.d;
        if (s1_err) begin
            next_diff = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_err    <= 1'b0;
            range_err <= 1'b0;
        end else begin
            if (adv1 && in_valid) begin
                s1_err <= in_err;
            end
            if (adv2 && s1.valid) begin
                range_err <= s1_err;
            end
        end
    end
`else
    always_comb begin
        next_diff = s1.borrow ? fix_d : s1.d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1         <= '0;
            out_valid  <= 1'b0;
            diff_out   <= '0;
            borrow_out <= 1'b0;
        end else begin
            if (adv1) begin
                s1.valid <= in_valid;
                if (in_valid) begin
                    s1.d      <= sub_d;
                    s1.borrow <= ~sub_c;
                end
            end
            if (adv2) begin
                out_valid <= s1.valid;
                if (s1.valid) begin
                    diff_out   <= next_diff;
                    borrow_out <= s1.borrow;
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_mod_sub_pipe.sv
// Directed self-checking bench for cla_mod_sub_pipe (WIDTH=16, MODULUS=65521).
module tb_cla_mod_sub_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff_out;
    logic        borrow_out;
`ifdef CLA_MOD_SUB_RANGE_CHECK_EN
    logic        range_err;
`endif

    int n_vec;
    int n_err;

    logic [15:0] exp_d[$];
    logic        exp_b[$];
    logic        exp_r[$];

    cla_mod_sub_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff_out  (diff_out),
        .borrow_out(borrow_out)
`ifdef CLA_MOD_SUB_RANGE_CHECK_EN
        ,
        .range_err (range_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic bw, input logic r);
        exp_d.push_back(d);
        exp_b.push_back(bw);
        exp_r.push_back(r);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_d.size() == 0) begin
                check("extra_out", 32'd1, 32'd0);
            end else begin
                check("diff", 32'(diff_out), 32'(exp_d.pop_front()));
                check("borrow", 32'(borrow_out), 32'(exp_b.pop_front()));
`ifdef CLA_MOD_SUB_RANGE_CHECK_EN
                check("range_err", 32'(range_err), 32'(exp_r.pop_front()));
`else
                void'(exp_r.pop_front());
`endif
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] d, input logic bw, input logic r);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_rdy", 32'(in_ready), 32'd1);
        push(d, bw, r);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic lat_test(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] d, input logic bw);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        @(negedge clk);
        check("lat_rdy", 32'(in_ready), 32'd1);
        push(d, bw, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_edge_n", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_edge_n1", 32'(out_valid), 32'd1);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff_out), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        lat_test(16'd5, 16'd3, 16'd2, 1'b0);

        send(16'd3, 16'd5, 16'd65519, 1'b1, 1'b0);
        send(16'd0, 16'd65520, 16'd1, 1'b1, 1'b0);
        send(16'd100, 16'd100, 16'd0, 1'b0, 1'b0);
        send(16'd65520, 16'd0, 16'd65520, 1'b0, 1'b0);
        repeat (4) @(posedge clk);

        // Fill both stages with the sink stalled.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a_in      = 16'd10;
        b_in      = 16'd4;
        push(16'd6, 1'b0, 1'b0);
        @(negedge clk);
        check("stall_rdy0", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        a_in = 16'd4;
        b_in = 16'd10;
        push(16'd65515, 1'b1, 1'b0);
        @(negedge clk);
        check("stall_rdy1", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        a_in = 16'd7;
        b_in = 16'd7;
        repeat (4) begin
            @(negedge clk);
            check("stall_full", 32'(in_ready), 32'd0);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_hold", 32'(diff_out), 32'd6);
        end
        push(16'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        check("stall_drain", 32'(exp_d.size()), 32'd0);

        // Two results in flight, then reset.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a_in      = 16'd20;
        b_in      = 16'd5;
        @(posedge clk);
        #1;
        a_in = 16'd30;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_rdy", 32'(in_ready), 32'd1);

        lat_test(16'd9, 16'd2, 16'd7, 1'b0);

`ifdef CLA_MOD_SUB_RANGE_CHECK_EN
        send(16'd65521, 16'd1, 16'd0, 1'b0, 1'b1);
        send(16'd1, 16'd1, 16'd0, 1'b0, 1'b0);
`endif

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("final_drain", 32'(exp_d.size()), 32'd0);
        check("final_idle", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
